// File: rtl/peri_bridge_axil_if.sv
// Core request/completion port plus the five AXI4-Lite channels to the peripheral interconnect.
// The master modport is the bridge's view; the slave modport is the core/interconnect side.
interface peri_bridge_axil_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic                  START;
    logic [ADDR_WIDTH-1:0] ADDRESS;
    logic                  WRITE;
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic [STRB_W-1:0]     WSTRB;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic                  DONE;
    logic                  ERROR;
    logic                  CACHE_READY_DAT;

    logic [ADDR_WIDTH-1:0] RD_ADDR_TO_PERI;
    logic                  RD_ADDR_TO_PERI_VALID;
    logic                  RD_ADDR_TO_PERI_READY;
    logic [DATA_WIDTH-1:0] DATA_FROM_PERI;
    logic [1:0]            DATA_FROM_PERI_RESP;
    logic                  DATA_FROM_PERI_VALID;
    logic                  DATA_FROM_PERI_READY;
    logic [ADDR_WIDTH-1:0] WR_ADDR_TO_PERI;
    logic                  WR_ADDR_TO_PERI_VALID;
    logic                  WR_ADDR_TO_PERI_READY;
    logic [DATA_WIDTH-1:0] DATA_TO_PERI;
    logic [STRB_W-1:0]     WSTRB_OUT;
    logic                  DATA_TO_PERI_VALID;
    logic                  DATA_TO_PERI_READY;
    logic [1:0]            WR_RESP_FROM_PERI;
    logic                  WR_RESP_VALID;
    logic                  WR_RESP_READY;

    modport master (
        input  START, ADDRESS, WRITE, DATA_IN, WSTRB, CACHE_READY_DAT,
        input  RD_ADDR_TO_PERI_READY, DATA_FROM_PERI, DATA_FROM_PERI_RESP, DATA_FROM_PERI_VALID,
        input  WR_ADDR_TO_PERI_READY, DATA_TO_PERI_READY, WR_RESP_FROM_PERI, WR_RESP_VALID,
        output DATA_OUT, DONE, ERROR,
        output RD_ADDR_TO_PERI, RD_ADDR_TO_PERI_VALID, DATA_FROM_PERI_READY,
        output WR_ADDR_TO_PERI, WR_ADDR_TO_PERI_VALID, DATA_TO_PERI, WSTRB_OUT,
        output DATA_TO_PERI_VALID, WR_RESP_READY
    );

    modport slave (
        output START, ADDRESS, WRITE, DATA_IN, WSTRB, CACHE_READY_DAT,
        output RD_ADDR_TO_PERI_READY, DATA_FROM_PERI, DATA_FROM_PERI_RESP, DATA_FROM_PERI_VALID,
        output WR_ADDR_TO_PERI_READY, DATA_TO_PERI_READY, WR_RESP_FROM_PERI, WR_RESP_VALID,
        input  DATA_OUT, DONE, ERROR,
        input  RD_ADDR_TO_PERI, RD_ADDR_TO_PERI_VALID, DATA_FROM_PERI_READY,
        input  WR_ADDR_TO_PERI, WR_ADDR_TO_PERI_VALID, DATA_TO_PERI, WSTRB_OUT,
        input  DATA_TO_PERI_VALID, WR_RESP_READY
    );
endinterface

// File: rtl/peri_bridge_axil.sv
// Single-beat core load/store to AXI4-Lite master bridge with response checking and timeout.
// Latency: 3 cycles START->DONE with zero-wait slaves; all outputs registered.
// Backpressure: VALIDs hold payload until READY; DONE held until CACHE_READY_DAT; abort after TIMEOUT_CYCLES.
module peri_bridge_axil #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               CLK,
    input  logic               RSTN,
    peri_bridge_axil_if.master bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_M1  = (TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit TO_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TO_M1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  block_q, block_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic                  ar_vld_q, ar_vld_d;
    logic                  r_rdy_q, r_rdy_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  aw_vld_q, aw_vld_d;
    logic [DATA_WIDTH-1:0] w_dat_q, w_dat_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  w_vld_q, w_vld_d;
    logic                  b_rdy_q, b_rdy_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  abort;

    logic hs_ar, hs_r, hs_aw, hs_w, hs_b, timeout_hit, busy;

    assign hs_ar = ar_vld_q & bus.RD_ADDR_TO_PERI_READY;
    assign hs_r  = r_rdy_q  & bus.DATA_FROM_PERI_VALID;
    assign hs_aw = aw_vld_q & bus.WR_ADDR_TO_PERI_READY;
    assign hs_w  = w_vld_q  & bus.DATA_TO_PERI_READY;
    assign hs_b  = b_rdy_q  & bus.WR_RESP_VALID;
    assign busy  = (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA) ||
                   (state_q == ST_WR_REQ)  || (state_q == ST_WR_RESP);
    // cnt_q counts cycles already spent, so the abort edge is the TIMEOUT_CYCLES-th busy cycle.
    assign timeout_hit = TO_EN && (cnt_q >= TO_LIMIT);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        block_d   = block_q;
        ar_addr_d = ar_addr_q;
        ar_vld_d  = ar_vld_q;
        r_rdy_d   = r_rdy_q;
        aw_addr_d = aw_addr_q;
        aw_vld_d  = aw_vld_q;
        w_dat_d   = w_dat_q;
        w_strb_d  = w_strb_q;
        w_vld_d   = w_vld_q;
        b_rdy_d   = b_rdy_q;
        dout_d    = dout_q;
        done_d    = done_q;
        err_d     = err_q;
        abort     = 1'b0;

        // A START held across completion must drop once before it can launch another request.
        if (!bus.START) block_d = 1'b0;
        if (busy && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.START && !done_q && !block_q) begin
                    cnt_d   = '0;
                    block_d = 1'b1;
                    if (bus.WRITE) begin
                        aw_addr_d = bus.ADDRESS;
                        w_dat_d   = bus.DATA_IN;
                        w_strb_d  = bus.WSTRB;
                        aw_vld_d  = 1'b1;
                        w_vld_d   = 1'b1;
                        state_d   = ST_WR_REQ;
                    end else begin
                        ar_addr_d = bus.ADDRESS;
                        ar_vld_d  = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (hs_ar) begin
                    ar_vld_d = 1'b0;
                    r_rdy_d  = 1'b1;
                    state_d  = ST_RD_DATA;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (hs_r) begin
                    r_rdy_d = 1'b0;
                    dout_d  = bus.DATA_FROM_PERI;
                    err_d   = bus.DATA_FROM_PERI_RESP[1];
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            ST_WR_REQ: begin
                if (hs_aw) aw_vld_d = 1'b0;
                if (hs_w)  w_vld_d  = 1'b0;
                if (!aw_vld_d && !w_vld_d) begin
                    b_rdy_d = 1'b1;
                    state_d = ST_WR_RESP;
                end else if (!hs_aw && !hs_w && timeout_hit) begin
                    abort = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (hs_b) begin
                    b_rdy_d = 1'b0;
                    err_d   = bus.WR_RESP_FROM_PERI[1];
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.CACHE_READY_DAT) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            ar_vld_d = 1'b0;
            r_rdy_d  = 1'b0;
            aw_vld_d = 1'b0;
            w_vld_d  = 1'b0;
            b_rdy_d  = 1'b0;
            dout_d   = '0;
            err_d    = 1'b1;
            done_d   = 1'b1;
            state_d  = ST_DONE;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            block_q   <= 1'b0;
            ar_addr_q <= '0;
            ar_vld_q  <= 1'b0;
            r_rdy_q   <= 1'b0;
            aw_addr_q <= '0;
            aw_vld_q  <= 1'b0;
            w_dat_q   <= '0;
            w_strb_q  <= '0;
            w_vld_q   <= 1'b0;
            b_rdy_q   <= 1'b0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            block_q   <= block_d;
            ar_addr_q <= ar_addr_d;
            ar_vld_q  <= ar_vld_d;
            r_rdy_q   <= r_rdy_d;
            aw_addr_q <= aw_addr_d;
            aw_vld_q  <= aw_vld_d;
            w_dat_q   <= w_dat_d;
            w_strb_q  <= w_strb_d;
            w_vld_q   <= w_vld_d;
            b_rdy_q   <= b_rdy_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.DATA_OUT              = dout_q;
    assign bus.DONE                  = done_q;
    assign bus.ERROR                 = err_q;
    assign bus.RD_ADDR_TO_PERI       = ar_addr_q;
    assign bus.RD_ADDR_TO_PERI_VALID = ar_vld_q;
    assign bus.DATA_FROM_PERI_READY  = r_rdy_q;
    assign bus.WR_ADDR_TO_PERI       = aw_addr_q;
    assign bus.WR_ADDR_TO_PERI_VALID = aw_vld_q;
    assign bus.DATA_TO_PERI          = w_dat_q;
    assign bus.WSTRB_OUT             = w_strb_q;
    assign bus.DATA_TO_PERI_VALID    = w_vld_q;
    assign bus.WR_RESP_READY         = b_rdy_q;
endmodule

// File: tb/tb_peri_bridge_axil.sv
// Scenario bench for peri_bridge_axil: scripted slaves, expected completions queued at request time.
module tb_peri_bridge_axil;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic CLK = 1'b0;
    logic RSTN;
    always #5 CLK = ~CLK;

    peri_bridge_axil_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
    peri_bridge_axil #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK (CLK),
        .RSTN(RSTN),
        .bus (bus)
    );

    typedef struct packed { logic [31:0] data; logic err; } exp_t;
    exp_t sb[$];
    exp_t e;
    int n_checks = 0;
    int n_fail   = 0;
    int ar_beats = 0, r_beats = 0, aw_beats = 0, w_beats = 0, b_beats = 0, b_early = 0;
    logic [31:0] model_dout = 32'h0;
    logic [138:0] all_outs;

    assign all_outs = {bus.DATA_OUT, bus.DONE, bus.ERROR, bus.RD_ADDR_TO_PERI, bus.RD_ADDR_TO_PERI_VALID,
                       bus.DATA_FROM_PERI_READY, bus.WR_ADDR_TO_PERI, bus.WR_ADDR_TO_PERI_VALID,
                       bus.DATA_TO_PERI, bus.WSTRB_OUT, bus.DATA_TO_PERI_VALID, bus.WR_RESP_READY};

    always @(posedge CLK) begin
        if (bus.WR_RESP_READY && bus.WR_RESP_VALID) begin
            if (aw_beats != b_beats + 1 || w_beats != b_beats + 1) b_early++;
            b_beats++;
        end
        if (bus.RD_ADDR_TO_PERI_VALID && bus.RD_ADDR_TO_PERI_READY) ar_beats++;
        if (bus.DATA_FROM_PERI_VALID && bus.DATA_FROM_PERI_READY) r_beats++;
        if (bus.WR_ADDR_TO_PERI_VALID && bus.WR_ADDR_TO_PERI_READY) aw_beats++;
        if (bus.DATA_TO_PERI_VALID && bus.DATA_TO_PERI_READY) w_beats++;
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic drive_idle();
        bus.START = 0; bus.ADDRESS = '0; bus.WRITE = 0; bus.DATA_IN = '0; bus.WSTRB = '0;
        bus.CACHE_READY_DAT = 0; bus.RD_ADDR_TO_PERI_READY = 0; bus.DATA_FROM_PERI = '0;
        bus.DATA_FROM_PERI_RESP = 2'b00; bus.DATA_FROM_PERI_VALID = 0; bus.WR_ADDR_TO_PERI_READY = 0;
        bus.DATA_TO_PERI_READY = 0; bus.WR_RESP_FROM_PERI = 2'b00; bus.WR_RESP_VALID = 0;
    endtask

    task automatic ack();
        bus.START = 0; bus.CACHE_READY_DAT = 1;
        tick();
        bus.CACHE_READY_DAT = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        RSTN = 1'b1;
        #1 RSTN = 1'b0;
        tick(); tick();
        n_checks++;
        if (all_outs !== '0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", all_outs); end
        RSTN = 1'b1;
        tick();
        n_checks++;
        if (all_outs !== '0) begin n_fail++; $display("FAIL idle_outs: got %h want 0", all_outs); end
    endtask

    task automatic test_read_zero_wait();
        bus.RD_ADDR_TO_PERI_READY = 1; bus.DATA_FROM_PERI = 32'hDEADBEEF;
        bus.DATA_FROM_PERI_RESP = 2'b00; bus.DATA_FROM_PERI_VALID = 1;
        bus.START = 1; bus.WRITE = 0; bus.ADDRESS = 32'h4000_0010;
        sb.push_back('{32'hDEADBEEF, 1'b0}); model_dout = 32'hDEADBEEF;
        tick();
        n_checks++;
        if ({bus.RD_ADDR_TO_PERI_VALID, bus.DATA_FROM_PERI_READY, bus.RD_ADDR_TO_PERI} !== {2'b10, 32'h4000_0010}) begin
            n_fail++; $display("FAIL rd_c1_ar: got v=%b rr=%b a=%h want v=1 rr=0 a=40000010",
                bus.RD_ADDR_TO_PERI_VALID, bus.DATA_FROM_PERI_READY, bus.RD_ADDR_TO_PERI);
        end
        tick();
        n_checks++;
        if ({bus.RD_ADDR_TO_PERI_VALID, bus.DATA_FROM_PERI_READY, bus.DONE} !== 3'b010) begin
            n_fail++; $display("FAIL rd_c2_rready: got arv/rr/done=%b%b%b want 010",
                bus.RD_ADDR_TO_PERI_VALID, bus.DATA_FROM_PERI_READY, bus.DONE);
        end
        tick();
        n_checks++;
        if ({bus.DONE, bus.DATA_FROM_PERI_READY} !== 2'b10) begin
            n_fail++; $display("FAIL rd_c3_done: got done=%b rr=%b want done=1 rr=0", bus.DONE, bus.DATA_FROM_PERI_READY);
        end
        e = sb.pop_front();
        n_checks++;
        if ({bus.DATA_OUT, bus.ERROR} !== {e.data, e.err}) begin
            n_fail++; $display("FAIL rd_result: got %h/%b want %h/%b", bus.DATA_OUT, bus.ERROR, e.data, e.err);
        end
        bus.START = 0; bus.DATA_FROM_PERI_VALID = 0; bus.RD_ADDR_TO_PERI_READY = 0;
        tick(); tick();
        n_checks++;
        if (bus.DONE !== 1'b1) begin n_fail++; $display("FAIL rd_done_held: got %b want 1", bus.DONE); end
        ack();
        n_checks++;
        if ({bus.DONE, bus.ERROR} !== 2'b00) begin
            n_fail++; $display("FAIL rd_done_fall: got done=%b err=%b want 00", bus.DONE, bus.ERROR);
        end
    endtask

    task automatic test_write_aw_delay();
        bus.DATA_TO_PERI_READY = 1; bus.WR_ADDR_TO_PERI_READY = 0;
        bus.WR_RESP_VALID = 1; bus.WR_RESP_FROM_PERI = 2'b10;
        bus.START = 1; bus.WRITE = 1; bus.ADDRESS = 32'h4000_0020; bus.DATA_IN = 32'hCAFE_F00D; bus.WSTRB = 4'b0011;
        sb.push_back('{model_dout, 1'b1});
        tick();
        n_checks++;
        if ({bus.WR_ADDR_TO_PERI_VALID, bus.DATA_TO_PERI_VALID, bus.WR_RESP_READY, bus.DATA_TO_PERI, bus.WSTRB_OUT}
                !== {3'b110, 32'hCAFE_F00D, 4'b0011}) begin
            n_fail++; $display("FAIL wr_c1: got awv/wv/br=%b%b%b d=%h s=%b want 110 cafef00d 0011",
                bus.WR_ADDR_TO_PERI_VALID, bus.DATA_TO_PERI_VALID, bus.WR_RESP_READY, bus.DATA_TO_PERI, bus.WSTRB_OUT);
        end
        for (int c = 2; c <= 4; c++) begin
            tick();
            n_checks++;
            if ({bus.WR_ADDR_TO_PERI_VALID, bus.DATA_TO_PERI_VALID, bus.WR_RESP_READY, bus.WR_ADDR_TO_PERI}
                    !== {3'b100, 32'h4000_0020}) begin
                n_fail++; $display("FAIL wr_aw_hold c%0d: got awv/wv/br=%b%b%b a=%h want 100 40000020", c,
                    bus.WR_ADDR_TO_PERI_VALID, bus.DATA_TO_PERI_VALID, bus.WR_RESP_READY, bus.WR_ADDR_TO_PERI);
            end
            if (c == 4) bus.WR_ADDR_TO_PERI_READY = 1;
        end
        tick();
        bus.WR_ADDR_TO_PERI_READY = 0;
        n_checks++;
        if ({bus.WR_ADDR_TO_PERI_VALID, bus.DATA_TO_PERI_VALID, bus.WR_RESP_READY, bus.DONE} !== 4'b0010) begin
            n_fail++; $display("FAIL wr_c5_bready: got awv/wv/br/done=%b%b%b%b want 0010",
                bus.WR_ADDR_TO_PERI_VALID, bus.DATA_TO_PERI_VALID, bus.WR_RESP_READY, bus.DONE);
        end
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({bus.DONE, bus.DATA_OUT, bus.ERROR} !== {1'b1, e.data, e.err}) begin
            n_fail++; $display("FAIL wr_slverr: got done=%b d=%h err=%b want 1 %h %b", bus.DONE, bus.DATA_OUT, bus.ERROR, e.data, e.err);
        end
        bus.WR_RESP_VALID = 0; bus.DATA_TO_PERI_READY = 0;
        ack();
    endtask

    task automatic test_write_orders();
        int delays[2] = '{2, 0};
        int want_lat[2] = '{4, 3};
        for (int i = 0; i < 2; i++) begin
            int aw0 = aw_beats, w0 = w_beats, b0 = b_beats, k = 0;
            bus.WR_ADDR_TO_PERI_READY = (delays[i] == 0); bus.DATA_TO_PERI_READY = 1;
            bus.WR_RESP_VALID = 1; bus.WR_RESP_FROM_PERI = 2'b00;
            bus.START = 1; bus.WRITE = 1; bus.ADDRESS = 32'h4000_0100 + 32'(i * 4);
            bus.DATA_IN = 32'h5A5A_0000 + 32'(i); bus.WSTRB = 4'hF;
            sb.push_back('{model_dout, 1'b0});
            while (bus.DONE !== 1'b1 && k < 20) begin
                tick(); k++;
                if (k == delays[i]) bus.WR_ADDR_TO_PERI_READY = 1;
            end
            n_checks++;
            if (k !== want_lat[i]) begin n_fail++; $display("FAIL wr_order%0d_latency: got %0d want %0d", i, k, want_lat[i]); end
            e = sb.pop_front();
            n_checks++;
            if ({bus.DONE, bus.ERROR, bus.DATA_OUT} !== {1'b1, e.err, e.data}) begin
                n_fail++; $display("FAIL wr_order%0d_result: got done=%b err=%b d=%h want 1 %b %h", i, bus.DONE, bus.ERROR, bus.DATA_OUT, e.err, e.data);
            end
            n_checks++;
            if ((aw_beats - aw0) != 1 || (w_beats - w0) != 1 || (b_beats - b0) != 1) begin
                n_fail++; $display("FAIL wr_order%0d_beats: got aw=%0d w=%0d b=%0d want 1 1 1", i, aw_beats - aw0, w_beats - w0, b_beats - b0);
            end
            bus.WR_ADDR_TO_PERI_READY = 0; bus.DATA_TO_PERI_READY = 0; bus.WR_RESP_VALID = 0;
            ack();
        end
        n_checks++;
        if (b_early != 0) begin n_fail++; $display("FAIL b_before_aw_w: got %0d early B beats want 0", b_early); end
    endtask

    task automatic test_timeout();
        int k = 1;
        bus.RD_ADDR_TO_PERI_READY = 0; bus.DATA_FROM_PERI_VALID = 0;
        bus.START = 1; bus.WRITE = 0; bus.ADDRESS = 32'h4000_0040;
        sb.push_back('{32'h0, 1'b1}); model_dout = 32'h0;
        tick();
        n_checks++;
        if (bus.RD_ADDR_TO_PERI_VALID !== 1'b1) begin n_fail++; $display("FAIL to_arv_rise: got %b want 1", bus.RD_ADDR_TO_PERI_VALID); end
        while (bus.DONE !== 1'b1 && k < 20) begin tick(); k++; end
        n_checks++;
        if (k - 1 != TO) begin n_fail++; $display("FAIL to_cycles: got %0d want %0d", k - 1, TO); end
        e = sb.pop_front();
        n_checks++;
        if ({bus.DONE, bus.RD_ADDR_TO_PERI_VALID, bus.DATA_FROM_PERI_READY, bus.ERROR, bus.DATA_OUT} !== {3'b100, e.err, e.data}) begin
            n_fail++; $display("FAIL to_abort: got done/arv/rr=%b%b%b err=%b d=%h want 100 %b %h",
                bus.DONE, bus.RD_ADDR_TO_PERI_VALID, bus.DATA_FROM_PERI_READY, bus.ERROR, bus.DATA_OUT, e.err, e.data);
        end
        ack();
        // AR accepted on the very edge the timeout would fire: the read must complete normally.
        bus.START = 1; bus.ADDRESS = 32'h4000_0044; bus.DATA_FROM_PERI = 32'h0BAD_F00D; bus.DATA_FROM_PERI_RESP = 2'b00;
        sb.push_back('{32'h0BAD_F00D, 1'b0}); model_dout = 32'h0BAD_F00D;
        for (int c = 1; c <= TO; c++) tick();
        bus.RD_ADDR_TO_PERI_READY = 1; bus.DATA_FROM_PERI_VALID = 1;
        tick();
        bus.RD_ADDR_TO_PERI_READY = 0;
        n_checks++;
        if ({bus.RD_ADDR_TO_PERI_VALID, bus.DATA_FROM_PERI_READY, bus.DONE} !== 3'b010) begin
            n_fail++; $display("FAIL to_edge_hs: got arv/rr/done=%b%b%b want 010", bus.RD_ADDR_TO_PERI_VALID, bus.DATA_FROM_PERI_READY, bus.DONE);
        end
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({bus.DONE, bus.DATA_OUT, bus.ERROR} !== {1'b1, e.data, e.err}) begin
            n_fail++; $display("FAIL to_edge_result: got done=%b d=%h err=%b want 1 %h %b", bus.DONE, bus.DATA_OUT, bus.ERROR, e.data, e.err);
        end
        bus.DATA_FROM_PERI_VALID = 0;
        ack();
    endtask

    task automatic test_held_start();
        int a0 = ar_beats, k = 0;
        bus.RD_ADDR_TO_PERI_READY = 1; bus.DATA_FROM_PERI_VALID = 1; bus.DATA_FROM_PERI = 32'h1111_2222;
        bus.DATA_FROM_PERI_RESP = 2'b00;
        bus.START = 1; bus.WRITE = 0; bus.ADDRESS = 32'h4000_0080;
        sb.push_back('{32'h1111_2222, 1'b0}); model_dout = 32'h1111_2222;
        while (bus.DONE !== 1'b1 && k < 10) begin tick(); k++; end
        e = sb.pop_front();
        n_checks++;
        if ({bus.DONE, bus.DATA_OUT, bus.ERROR} !== {1'b1, e.data, e.err}) begin
            n_fail++; $display("FAIL held_first: got done=%b d=%h err=%b want 1 %h %b", bus.DONE, bus.DATA_OUT, bus.ERROR, e.data, e.err);
        end
        bus.CACHE_READY_DAT = 1;
        tick();
        bus.CACHE_READY_DAT = 0;
        for (int c = 0; c < 6; c++) tick();
        n_checks++;
        if ((ar_beats - a0) != 1 || bus.RD_ADDR_TO_PERI_VALID !== 1'b0 || bus.DONE !== 1'b0) begin
            n_fail++; $display("FAIL held_no_reissue: got ar=%0d arv=%b done=%b want 1 0 0", ar_beats - a0, bus.RD_ADDR_TO_PERI_VALID, bus.DONE);
        end
        bus.START = 0;
        tick();
        bus.START = 1; bus.DATA_FROM_PERI = 32'h3333_4444;
        sb.push_back('{32'h3333_4444, 1'b0}); model_dout = 32'h3333_4444;
        k = 0;
        while (bus.DONE !== 1'b1 && k < 10) begin tick(); k++; end
        e = sb.pop_front();
        n_checks++;
        if ({bus.DONE, bus.DATA_OUT, bus.ERROR} !== {1'b1, e.data, e.err} || (ar_beats - a0) != 2) begin
            n_fail++; $display("FAIL held_second: got done=%b d=%h err=%b ar=%0d want 1 %h %b 2", bus.DONE, bus.DATA_OUT, bus.ERROR, ar_beats - a0, e.data, e.err);
        end
        bus.RD_ADDR_TO_PERI_READY = 0; bus.DATA_FROM_PERI_VALID = 0;
        ack();
    endtask

    task automatic test_reset_midflight();
        int r0 = r_beats;
        bus.RD_ADDR_TO_PERI_READY = 1; bus.DATA_FROM_PERI_VALID = 0;
        bus.START = 1; bus.WRITE = 0; bus.ADDRESS = 32'h4000_00C0;
        tick(); tick();
        n_checks++;
        if (bus.DATA_FROM_PERI_READY !== 1'b1) begin n_fail++; $display("FAIL rst_pre_rready: got %b want 1", bus.DATA_FROM_PERI_READY); end
        bus.START = 0; bus.RD_ADDR_TO_PERI_READY = 0;
        #2 RSTN = 1'b0;
        #1;
        n_checks++;
        if (all_outs !== '0) begin n_fail++; $display("FAIL rst_async_outs: got %h want 0", all_outs); end
        tick(); tick();
        RSTN = 1'b1;
        tick();
        bus.DATA_FROM_PERI_VALID = 1; bus.DATA_FROM_PERI = 32'h7777_7777;
        tick();
        bus.DATA_FROM_PERI_VALID = 0;
        for (int c = 0; c < 3; c++) tick();
        n_checks++;
        if (all_outs !== '0 || r_beats != r0) begin
            n_fail++; $display("FAIL rst_stays_idle: got outs=%h rbeats=%0d want 0 %0d", all_outs, r_beats, r0);
        end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_aw_delay();
        test_write_orders();
        test_timeout();
        test_held_start();
        test_reset_midflight();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/peri_bridge_axil.md
Name: peri_bridge_axil

Overview:
Parametrised successor to the pipeline's single-beat peripheral port. Converts one core load/store request (START/ADDRESS/WRITE/DATA_IN/WSTRB) into an AXI4-Lite-style transaction on five independent channels (AR, R, AW, W, B). Adds response checking and a transaction timeout. Sits between the data-cache/MEM stage and the peripheral interconnect; DONE is held until the cache side acknowledges.

Parameters:
ADDR_WIDTH, 32, address width of request and AR/AW channels
DATA_WIDTH, 32, data width (multiple of 8); strobe width STRB_W = DATA_WIDTH/8
TIMEOUT_CYCLES, 256, cycles allowed per transaction before abort; 0 disables the timeout

Ports:
CLK  in  1  clock, rising edge
RSTN  in  1  asynchronous active-low reset
START  in  1  request valid, held by core until DONE
ADDRESS  in  ADDR_WIDTH  request address
WRITE  in  1  1 = store, 0 = load
DATA_IN  in  DATA_WIDTH  store data
WSTRB  in  STRB_W  store byte enables
DATA_OUT  out  DATA_WIDTH  load data, valid while DONE=1
DONE  out  1  transaction complete, held until CACHE_READY_DAT
ERROR  out  1  qualifies DONE: slave error or timeout
CACHE_READY_DAT  in  1  completion acknowledge from cache side
RD_ADDR_TO_PERI  out  ADDR_WIDTH  AR address
RD_ADDR_TO_PERI_VALID  out  1  AR valid
RD_ADDR_TO_PERI_READY  in  1  AR ready
DATA_FROM_PERI  in  DATA_WIDTH  R data
DATA_FROM_PERI_RESP  in  2  R response
DATA_FROM_PERI_VALID  in  1  R valid
DATA_FROM_PERI_READY  out  1  R ready
WR_ADDR_TO_PERI  out  ADDR_WIDTH  AW address
WR_ADDR_TO_PERI_VALID  out  1  AW valid
WR_ADDR_TO_PERI_READY  in  1  AW ready
DATA_TO_PERI  out  DATA_WIDTH  W data
WSTRB_OUT  out  STRB_W  W strobes
DATA_TO_PERI_VALID  out  1  W valid
DATA_TO_PERI_READY  in  1  W ready
WR_RESP_FROM_PERI  in  2  B response
WR_RESP_VALID  in  1  B valid
WR_RESP_READY  out  1  B ready

Behaviour:
- Reset (async, RSTN=0): state IDLE; all outputs 0, including DATA_OUT, DONE, ERROR, all VALID/READY, addresses, DATA_TO_PERI and WSTRB_OUT; timeout counter 0. A reset mid-transaction abandons it immediately and issues no further handshakes.
- Handshake rule: a beat transfers on a cycle where VALID&READY are both 1 at the clock edge. Once VALID is raised, it and its payload stay stable until transfer. VALID never depends combinationally on READY; all outputs are registered.
- IDLE: when START=1 and DONE=0, latch ADDRESS/DATA_IN/WSTRB. For a read, go to RD_ADDR with RD_ADDR_TO_PERI_VALID=1 the next cycle. For a write, go to WR_REQ with AW and W VALID both 1 the next cycle.
- RD_ADDR: on AR transfer, drop AR VALID, raise DATA_FROM_PERI_READY, go to RD_DATA. R beats are not accepted in RD_ADDR.
- RD_DATA: on R transfer, drop READY, set DATA_OUT=DATA_FROM_PERI and ERROR=RESP[1], go to DONE_ST.
- WR_REQ: AW and W handshake independently, in either order or in the same cycle. Each VALID drops on its own transfer. When both have transferred, raise WR_RESP_READY and go to WR_RESP. B is not accepted before then.
- WR_RESP: on B transfer, drop READY, set ERROR=RESP[1], go to DONE_ST. DATA_OUT is unchanged.
- DONE_ST: DONE=1 and is held. When CACHE_READY_DAT=1, DONE and ERROR go to 0 next cycle and the state returns to IDLE. START is ignored while DONE=1, so a held START after completion is not re-issued. A new request can be captured in the cycle after DONE falls.
- Timeout: the counter clears on leaving IDLE and increments every cycle in RD_ADDR/RD_DATA/WR_REQ/WR_RESP. When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0), drop all VALID/READY, set ERROR=1 and DATA_OUT=0, and go to DONE_ST. A handshake that lands on the same edge as the timeout wins: the transaction proceeds normally.
- Minimum latency, START high at cycle 0 with all slaves ready: read gives AR VALID at cycle 1, RREADY at cycle 2, DONE at cycle 3. Write gives AW/W at cycle 1, BREADY at cycle 2, DONE at cycle 3.
- Counter width is clog2(TIMEOUT_CYCLES+1), minimum 1.

Test Plan:
- Read, zero-wait slave, ADDRESS=0x4000_0010, R data 0xDEADBEEF, RESP=0 -> AR VALID at cycle 1, DONE=1 at cycle 3 with DATA_OUT=0xDEADBEEF, ERROR=0. DONE held until CACHE_READY_DAT pulses, then falls the next cycle.
- Write, WSTRB=4'b0011, AWREADY delayed 3 cycles, WREADY immediate -> W VALID drops after cycle 1, AW VALID holds with a stable address until cycle 4, BREADY rises at cycle 5. B RESP=2'b10 gives DONE=1 with ERROR=1.
- Write with W accepted before AW and again with both accepted in the same cycle -> exactly one AW and one W beat each, and B is accepted only after both.
- TIMEOUT_CYCLES=8, read with ARREADY held 0 -> AR VALID drops and DONE=1, ERROR=1, DATA_OUT=0 exactly 8 cycles after AR VALID rose. A later normal read succeeds.
- START held high through DONE and CACHE_READY_DAT -> exactly one transaction per START assertion window. Only a fresh cycle of START after DONE falls starts a second one.
- RSTN asserted while RD_DATA is waiting -> all outputs 0 asynchronously. After release, an R VALID pulse is ignored and the bridge stays idle.
